mult_issue_ctrl: RTL and testbench

Operand-side front end for the sequential shift-add signed multiplier (start/ready protocol, NB-cycle iteration).
- Accepts operand pairs over a valid/ready stream and queues them in a small FIFO.
- Issues one start pulse per pair to the multiplier and waits for its ready.
- Captures the 2*NB-bit product into an output register with valid/ready handshake, so upstream and downstream logic never see the raw start/ready timing.

---
 rtl/mult_issue_ctrl.sv | 137 +++++++++++++
 tb/tb_mult_issue_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_issue_ctrl.sv
// Operand FIFO + start/ready sequencer for a shift-add multiplier; push-to-result NB+3 cycles, one result per NB+2.
// in_ready = FIFO not full; a held output slot stalls the FSM in WAIT. Optional MULT_ZERO_BYPASS_EN skips zero pairs.
module mult_issue_ctrl #(
  parameter int NB    = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NB-1:0]            in_a,
  input  logic [NB-1:0]            in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*NB-1:0]          out_product,
  output logic                     mul_start,
  output logic [NB-1:0]            mul_a,
  output logic [NB-1:0]            mul_b,
  input  logic [2*NB-1:0]          mul_product,
  input  logic                     mul_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state;

  logic [NB-1:0] fifo_a [DEPTH];
  logic [NB-1:0] fifo_b [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop, fifo_empty, slot_free;
  logic [NB-1:0] head_a, head_b;

  assign fifo_empty = (count == '0);
  assign in_ready   = (count != CW'(DEPTH));
  assign push       = in_valid && in_ready;
  assign slot_free  = !out_valid || out_ready;
  assign head_a     = fifo_a[rd_ptr];
  assign head_b     = fifo_b[rd_ptr];
  assign fifo_count = count;
  assign busy       = (state != IDLE) || !fifo_empty;

`ifdef MULT_ZERO_BYPASS_EN
  logic bypass;
  assign bypass = (state == IDLE) && !fifo_empty && slot_free &&
                  ((head_a == '0) || (head_b == '0));
`endif

  // The FSM is the only consumer; a pop always takes the head pair.
  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE:    pop = !fifo_empty;
      WAIT:    pop = mul_ready && slot_free && !fifo_empty;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a[wr_ptr] <= in_a;
      fifo_b[wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mul_start   <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      out_valid   <= 1'b0;
      out_product <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
`ifdef MULT_ZERO_BYPASS_EN
            if (bypass) begin
              out_product <= '0;
              out_valid   <= 1'b1;
            end else
`endif
            begin
              mul_a     <= head_a;
              mul_b     <= head_b;
              mul_start <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          mul_start <= 1'b0;
          state     <= WAIT;
        end
        WAIT: begin
          // With the slot occupied we simply hold; the multiplier keeps its product until restarted.
          if (mul_ready && slot_free) begin
            out_product <= mul_product;
            out_valid   <= 1'b1;
            if (!fifo_empty) begin
              mul_a     <= head_a;
              mul_b     <= head_b;
              mul_start <= 1'b1;
              state     <= ISSUE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Bench for mult_issue_ctrl: behavioural shift-add multiplier model plus a push-order scoreboard.
module tb_mult_issue_ctrl;
  localparam int NB    = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid, in_ready;
  logic [NB-1:0]   in_a, in_b;
  logic            out_valid, out_ready;
  logic [2*NB-1:0] out_product;
  logic            mul_start;
  logic [NB-1:0]   mul_a, mul_b;
  logic [2*NB-1:0] mul_product;
  logic            mul_ready;
  logic [2:0]      fifo_count;
  logic            busy;

  mult_issue_ctrl #(.NB(NB), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_product(mul_product), .mul_ready(mul_ready),
    .fifo_count(fifo_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Multiplier model: no reset, start has priority, ready rises NB edges after start is sampled.
  logic [NB-1:0] m_a, m_b;
  int            m_cnt = 0;
  always @(posedge clk) begin
    if (mul_start) begin
      m_a       <= mul_a;
      m_b       <= mul_b;
      m_cnt     <= NB;
      mul_ready <= 1'b0;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        mul_ready   <= 1'b1;
        mul_product <= {{NB{m_a[NB-1]}}, m_a} * {{NB{m_b[NB-1]}}, m_b};
      end
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  int n_start = 0;
  logic [2*NB-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return sa * sb;
  endfunction

  // Output monitor and scoreboard, sampled at the falling edge.
  always @(negedge clk) begin
    if (mul_start) n_start++;
    if (fifo_count == 3'(DEPTH)) check("full_in_ready", 64'(in_ready), 64'd0);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_result", 64'd1, 64'd0);
      else check("product", out_product, exp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    int t = 0;
    in_a = a; in_b = b; in_valid = 1'b1;
    while (!in_ready && t < 400) begin
      step();
      t++;
    end
    check("send_accepted", 64'(in_ready), 64'd1);
    if (in_ready) exp_q.push_back(exp);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      step();
      lat++;
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() > 0 || busy) && t < 3000) begin
      step();
      t++;
    end
    check("drain_queue", 64'(exp_q.size()), 64'd0);
    check("drain_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, ns0;
    logic [63:0] held;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    #12;
    check("rst_fifo_count", 64'(fifo_count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_product", out_product, 64'd0);
    check("rst_mul_start", 64'(mul_start), 64'd0);
    check("rst_mul_a", 64'(mul_a), 64'd0);
    check("rst_mul_b", 64'(mul_b), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // Basic product, latency and single start pulse.
    ns0 = n_start;
    send(32'd7, 32'd6, 64'd42);
    wait_valid(lat);
    check("lat_7x6", 64'(lat), 64'(NB + 3));
    check("start_pulses_7x6", 64'(n_start - ns0), 64'd1);
    drain();

    // Signed corner cases.
    send(32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
    send(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    drain();

    // Fill the FIFO against a stalled output, then check the WAIT hold.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++)
      send(32'(i * 1234 - 2000), 32'(-(i * 77) + 31), smul(32'(i * 1234 - 2000), 32'(-(i * 77) + 31)));
    repeat (120) step();
    ns0  = n_start;
    held = out_product;
    check("stall_out_valid", 64'(out_valid), 64'd1);
    check("stall_head", out_product, exp_q[0]);
    check("stall_busy", 64'(busy), 64'd1);
    repeat (20) step();
    check("stall_no_start", 64'(n_start - ns0), 64'd0);
    check("stall_product_held", out_product, held);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("pulse_out_valid", 64'(out_valid), 64'd1);
    check("pulse_second", out_product, exp_q[0]);
    out_ready = 1'b1;
    drain();

    // Reset while the multiplier is running.
    send(32'd11, 32'd13, 64'd143);
    repeat (10) step();
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_fifo_count", 64'(fifo_count), 64'd0);
    check("mid_rst_mul_start", 64'(mul_start), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    send(32'd2, 32'd3, 64'd6);
    wait_valid(lat);
    check("lat_after_rst", 64'(lat), 64'(NB + 3));
    drain();

    // Zero operand.
    ns0 = n_start;
    send(32'd0, 32'd9, 64'd0);
    wait_valid(lat);
`ifdef MULT_ZERO_BYPASS_EN
    check("zero_lat_bypass", 64'(lat <= 2), 64'd1);
    check("zero_no_start", 64'(n_start - ns0), 64'd0);
`else
    check("zero_lat", 64'(lat), 64'(NB + 3));
    check("zero_start", 64'(n_start - ns0), 64'd1);
`endif
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
